// File: rtl/rpc_cfg_boot_seq.sv
// +--------------------------------------------------------------------------+
// | rpc_cfg_boot_seq: reg-bus boot sequencer (table writes, then poll ready)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package rpc_cfg_boot_seq_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module rpc_cfg_boot_seq #(
  parameter int unsigned          NumWrites    = 4,
  parameter int unsigned          AddrWidth    = 32,
  parameter int unsigned          DataWidth    = 32,
  parameter logic [AddrWidth-1:0] PollAddr     = 32'h0000_0000,
  parameter logic [DataWidth-1:0] PollMask     = 32'h0000_0001,
  parameter int unsigned          PollInterval = 16,
  parameter int unsigned          MaxPolls     = 64,
  parameter type                  reg_req_t    = rpc_cfg_boot_seq_pkg::reg_req_t,
  parameter type                  reg_rsp_t    = rpc_cfg_boot_seq_pkg::reg_rsp_t
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic [NumWrites*AddrWidth-1:0]     seq_addr_i,
  input  logic [NumWrites*DataWidth-1:0]     seq_data_i,
  output reg_req_t                           reg_req_o,
  input  reg_rsp_t                           reg_rsp_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               fail_o,
  output logic [1:0]                         err_code_o,
  output logic [$clog2(NumWrites+1)-1:0]     fail_idx_o
);

  localparam int unsigned IDX_W    = $clog2(NumWrites + 1);
  localparam int unsigned POLL_W   = $clog2(MaxPolls + 1);
  localparam int unsigned WAIT_W   = $clog2(PollInterval + 1);
  localparam int unsigned TBL_SIZE = 2 ** IDX_W;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NumWrites - 1);
  localparam logic [IDX_W-1:0]  IDX_POLL  = IDX_W'(NumWrites);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MaxPolls - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(PollInterval - 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BUS     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_REQ    = 3'd1,
    S_POLL_REQ  = 3'd2,
    S_POLL_WAIT = 3'd3,
    S_DONE      = 3'd4,
    S_FAIL      = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;

  // Table padded to a power of two so idx never selects past the array.
  logic [AddrWidth-1:0] addr_tbl [TBL_SIZE];
  logic [DataWidth-1:0] data_tbl [TBL_SIZE];

  for (genvar k = 0; k < TBL_SIZE; k++) begin : g_tbl
    if (k < NumWrites) begin : g_used
      assign addr_tbl[k] = seq_addr_i[k*AddrWidth +: AddrWidth];
      assign data_tbl[k] = seq_data_i[k*DataWidth +: DataWidth];
    end else begin : g_pad
      assign addr_tbl[k] = '0;
      assign data_tbl[k] = '0;
    end
  end

  logic poll_ok;
  assign poll_ok = ((reg_rsp_i.rdata & PollMask) == PollMask);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    poll_cnt_d = poll_cnt_q;
    wait_d     = wait_q;
    err_code_d = err_code_q;
    fail_idx_d = fail_idx_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          state_d    = S_WR_REQ;
          idx_d      = '0;
          poll_cnt_d = '0;
          wait_d     = '0;
          err_code_d = ERR_NONE;
          fail_idx_d = '0;
        end
      end
      S_WR_REQ: begin
        if (reg_rsp_i.ready) begin
          if (reg_rsp_i.error) begin
            state_d    = S_FAIL;
            err_code_d = ERR_BUS;
            fail_idx_d = idx_q;
          end else if (idx_q == IDX_LAST) begin
            state_d = S_POLL_REQ;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_POLL_REQ: begin
        if (reg_rsp_i.ready) begin
          if (reg_rsp_i.error) begin
            state_d    = S_FAIL;
            err_code_d = ERR_BUS;
            fail_idx_d = IDX_POLL;
          end else if (poll_ok) begin
            state_d = S_DONE;
          end else if (poll_cnt_q == POLL_LAST) begin
            state_d    = S_FAIL;
            err_code_d = ERR_TIMEOUT;
            fail_idx_d = IDX_POLL;
          end else begin
            poll_cnt_d = poll_cnt_q + POLL_W'(1);
            wait_d     = WAIT_LOAD;
            state_d    = S_POLL_WAIT;
          end
        end
      end
      S_POLL_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_POLL_REQ;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      poll_cnt_q <= '0;
      wait_q     <= '0;
      err_code_q <= ERR_NONE;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
      wait_q     <= wait_d;
      err_code_q <= err_code_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // Request fields decode from registered state only, so they stay stable
  // for as long as the state waits on ready.
  always_comb begin
    reg_req_o = '0;
    case (state_q)
      S_WR_REQ: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b1;
        reg_req_o.addr  = addr_tbl[idx_q];
        reg_req_o.wdata = data_tbl[idx_q];
        reg_req_o.wstrb = '1;
      end
      S_POLL_REQ: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = PollAddr;
      end
      default: reg_req_o = '0;
    endcase
  end

  assign busy_o     = (state_q == S_WR_REQ) || (state_q == S_POLL_REQ) ||
                      (state_q == S_POLL_WAIT);
  assign done_o     = (state_q == S_DONE);
  assign fail_o     = (state_q == S_FAIL);
  assign err_code_o = err_code_q;
  assign fail_idx_o = fail_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_rpc_cfg_boot_seq.sv
// +--------------------------------------------------------------------------+
// | tb_rpc_cfg_boot_seq: randomized bench with transaction-level model        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rpc_cfg_boot_seq;

  localparam int          NW            = 4;
  localparam int          MAX_POLLS     = 3;
  localparam int          POLL_INTERVAL = 16;
  localparam logic [31:0] POLL_ADDR     = 32'h0000_0040;
  localparam logic [31:0] POLL_MASK     = 32'h0000_0001;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waitc;
    logic        err;
    logic [31:0] rdata;
    int          gap;
  } txn_t;

  logic clk;
  logic rst_ni;
  logic start_i;
  logic [NW*32-1:0] seq_addr;
  logic [NW*32-1:0] seq_data;
  rpc_cfg_boot_seq_pkg::reg_req_t req;
  rpc_cfg_boot_seq_pkg::reg_rsp_t rsp;
  logic       busy_o, done_o, fail_o;
  logic [1:0] err_code_o;
  logic [2:0] fail_idx_o;

  rpc_cfg_boot_seq #(
    .NumWrites   (NW),
    .AddrWidth   (32),
    .DataWidth   (32),
    .PollAddr    (POLL_ADDR),
    .PollMask    (POLL_MASK),
    .PollInterval(POLL_INTERVAL),
    .MaxPolls    (MAX_POLLS)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .seq_addr_i(seq_addr),
    .seq_data_i(seq_data),
    .reg_req_o (req),
    .reg_rsp_i (rsp),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .fail_o    (fail_o),
    .err_code_o(err_code_o),
    .fail_idx_o(fail_idx_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scenario the responder plays out and the model predicts from.
  logic [31:0] tbl_addr [NW];
  logic [31:0] tbl_data [NW];
  int          wr_wait  [NW];
  logic        wr_err   [NW];
  int          poll_wait[MAX_POLLS];
  logic        poll_err [MAX_POLLS];
  logic [31:0] poll_data[MAX_POLLS];

  assign seq_addr = {tbl_addr[3], tbl_addr[2], tbl_addr[1], tbl_addr[0]};
  assign seq_data = {tbl_data[3], tbl_data[2], tbl_data[1], tbl_data[0]};

  txn_t exp_q[$];
  logic       exp_done, exp_fail;
  logic [1:0] exp_code;
  logic [2:0] exp_idx;
  logic       h_done = 1'b0, h_fail = 1'b0;
  logic [1:0] h_code = 2'd0;
  logic [2:0] h_idx  = 3'd0;
  logic       model_busy = 1'b0;

  // Expected bus transactions and final verdict for one start pulse.
  function automatic void build_model();
    txn_t t;
    exp_q.delete();
    exp_done = 1'b0; exp_fail = 1'b0; exp_code = 2'd0; exp_idx = 3'd0;
    for (int k = 0; k < NW; k++) begin
      t.addr = tbl_addr[k]; t.write = 1'b1; t.wdata = tbl_data[k]; t.wstrb = 4'hF;
      t.waitc = wr_wait[k]; t.err = wr_err[k]; t.rdata = $urandom; t.gap = 0;
      exp_q.push_back(t);
      if (wr_err[k]) begin
        exp_fail = 1'b1; exp_code = 2'd1; exp_idx = 3'(k);
        return;
      end
    end
    for (int p = 0; p < MAX_POLLS; p++) begin
      t.addr = POLL_ADDR; t.write = 1'b0; t.wdata = '0; t.wstrb = '0;
      t.waitc = poll_wait[p]; t.err = poll_err[p]; t.rdata = poll_data[p];
      t.gap = (p == 0) ? 0 : POLL_INTERVAL;
      exp_q.push_back(t);
      if (poll_err[p]) begin
        exp_fail = 1'b1; exp_code = 2'd1; exp_idx = 3'(NW);
        return;
      end
      if ((poll_data[p] & POLL_MASK) == POLL_MASK) begin
        exp_done = 1'b1;
        return;
      end
    end
    exp_fail = 1'b1; exp_code = 2'd2; exp_idx = 3'(NW);
  endfunction

  // Responder plus per-cycle compare against the model.
  initial begin : mon
    int   t_idx, idle, wait_left;
    logic first;
    t_idx = 0; idle = 0; wait_left = 0; first = 1'b1;
    rsp = '0;
    forever begin
      @(negedge clk);
      rsp.ready = 1'b0;
      rsp.error = 1'b0;
      rsp.rdata = $urandom;
      if (!rst_ni) begin
        chk("rst_req_zero", 64'(req == '0), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_fail", 64'(fail_o), 64'd0);
        chk("rst_code", 64'(err_code_o), 64'd0);
        chk("rst_idx", 64'(fail_idx_o), 64'd0);
        model_busy = 1'b0;
        h_done = 1'b0; h_fail = 1'b0; h_code = 2'd0; h_idx = 3'd0;
        continue;
      end
      if (model_busy && t_idx < exp_q.size()) begin
        chk("run_busy", 64'(busy_o), 64'd1);
        chk("run_done", 64'(done_o), 64'd0);
        chk("run_fail", 64'(fail_o), 64'd0);
        if (req.valid) begin
          if (first) begin
            chk("req_gap", 64'(idle), 64'(exp_q[t_idx].gap));
            first = 1'b0;
            wait_left = exp_q[t_idx].waitc;
          end
          chk("req_addr", 64'(req.addr), 64'(exp_q[t_idx].addr));
          chk("req_write", 64'(req.write), 64'(exp_q[t_idx].write));
          chk("req_wdata", 64'(req.wdata), 64'(exp_q[t_idx].wdata));
          chk("req_wstrb", 64'(req.wstrb), 64'(exp_q[t_idx].wstrb));
          if (wait_left == 0) begin
            rsp.ready = 1'b1;
            rsp.error = exp_q[t_idx].err;
            rsp.rdata = exp_q[t_idx].rdata;
            t_idx++;
            first = 1'b1;
            idle = 0;
          end else begin
            wait_left--;
          end
        end else begin
          idle++;
          if (idle > 64) begin
            chk("req_stall_gap", 64'(idle), 64'(exp_q[t_idx].gap));
            model_busy = 1'b0;
          end
        end
      end else if (model_busy) begin
        chk("end_valid", 64'(req.valid), 64'd0);
        chk("end_busy", 64'(busy_o), 64'd0);
        chk("end_done", 64'(done_o), 64'(exp_done));
        chk("end_fail", 64'(fail_o), 64'(exp_fail));
        chk("end_code", 64'(err_code_o), 64'(exp_code));
        chk("end_idx", 64'(fail_idx_o), 64'(exp_idx));
        h_done = exp_done; h_fail = exp_fail; h_code = exp_code; h_idx = exp_idx;
        model_busy = 1'b0;
      end else begin
        chk("hold_req_zero", 64'(req == '0), 64'd1);
        chk("hold_busy", 64'(busy_o), 64'd0);
        chk("hold_done", 64'(done_o), 64'(h_done));
        chk("hold_fail", 64'(fail_o), 64'(h_fail));
        chk("hold_code", 64'(err_code_o), 64'(h_code));
        chk("hold_idx", 64'(fail_idx_o), 64'(h_idx));
      end
      if (start_i && !model_busy) begin
        build_model();
        model_busy = 1'b1;
        t_idx = 0;
        idle = 0;
        first = 1'b1;
      end
    end
  end

  task automatic set_clean();
    for (int k = 0; k < NW; k++) begin
      tbl_addr[k] = $urandom; tbl_data[k] = $urandom;
      wr_wait[k] = 0; wr_err[k] = 1'b0;
    end
    for (int p = 0; p < MAX_POLLS; p++) begin
      poll_wait[p] = 0; poll_err[p] = 1'b0; poll_data[p] = 32'h1;
    end
  endtask

  task automatic set_random();
    for (int k = 0; k < NW; k++) begin
      tbl_addr[k] = $urandom; tbl_data[k] = $urandom;
      wr_wait[k] = $urandom_range(0, 3);
      wr_err[k]  = ($urandom_range(0, 11) == 0);
    end
    for (int p = 0; p < MAX_POLLS; p++) begin
      poll_wait[p] = $urandom_range(0, 2);
      poll_err[p]  = ($urandom_range(0, 14) == 0);
      poll_data[p] = ($urandom_range(0, 2) == 0) ? ($urandom | 32'h1) : ($urandom & ~32'h1);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  // Pulse start and count cycles until done/fail; optional extra start mid-run.
  task automatic run_seq(input string name, input int exp_n, input logic e_done,
                         input logic [1:0] e_code, input logic [2:0] e_idx, input int mid_at);
    int n;
    n = 0;
    start_i = 1'b1;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      start_i = (n == mid_at);
      if (done_o || fail_o) break;
    end
    start_i = 1'b0;
    chk({name, "_cycles"}, 64'(n), 64'(exp_n));
    chk({name, "_done"}, 64'(done_o), 64'(e_done));
    chk({name, "_fail"}, 64'(fail_o), 64'(!e_done));
    chk({name, "_code"}, 64'(err_code_o), 64'(e_code));
    chk({name, "_idx"}, 64'(fail_idx_o), 64'(e_idx));
    if (n >= 2000) do_reset();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    rst_ni  = 1'b0;
    start_i = 1'b0;
    set_clean();
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Clean pass: four writes, one successful poll.
    set_clean();
    run_seq("t1_clean", 6, 1'b1, 2'd0, 3'd0, 0);

    // Three wait cycles on write 2.
    set_clean();
    wr_wait[2] = 3;
    run_seq("t2_wait", 9, 1'b1, 2'd0, 3'd0, 0);

    // Bus error on write 1.
    set_clean();
    wr_err[1] = 1'b1;
    run_seq("t3_wrerr", 3, 1'b0, 2'd1, 3'd1, 0);

    // Status never ready: three polls, then timeout.
    set_clean();
    for (int p = 0; p < MAX_POLLS; p++) poll_data[p] = 32'h0;
    run_seq("t4_timeout", 40, 1'b0, 2'd2, 3'd4, 0);

    // Ready on third poll, with an ignored start during the wait.
    set_clean();
    poll_data[0] = 32'h0; poll_data[1] = 32'h0; poll_data[2] = 32'h3;
    run_seq("t5_third", 40, 1'b1, 2'd0, 3'd0, 10);

    // Reset while write 1 is pending, then rerun from index 0.
    set_clean();
    wr_wait[1] = 6;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_pending_valid", 64'(req.valid), 64'd1);
    chk("t6_pending_addr", 64'(req.addr), 64'(tbl_addr[1]));
    rst_ni = 1'b0;
    #1;
    chk("t6_async_req_zero", 64'(req == '0), 64'd1);
    chk("t6_async_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    set_clean();
    run_seq("t6_rerun", 6, 1'b1, 2'd0, 3'd0, 0);

    // Randomized scenarios, judged by the model.
    for (int r = 0; r < 30; r++) begin
      int n;
      set_random();
      start_i = 1'b1;
      n = 0;
      while (n < 2000) begin
        @(posedge clk);
        #1;
        n++;
        start_i = 1'b0;
        if (done_o || fail_o) break;
      end
      start_i = 1'b0;
      if (n >= 2000) begin
        chk("rand_timeout", 64'(n), 64'd0);
        do_reset();
      end
      repeat (3) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
